// File: rtl/multi_port_reg_file_if.sv
// Register file access bundle: read ports, two writeback
// ports, scoreboard issue port and busy status.
interface multi_port_reg_file_if #(
  parameter int W  = 8,
  parameter int D  = 4,
  parameter int NR = 2
);
  logic [NR*D-1:0] Raddr;
  logic [NR*W-1:0] DataOut;
  logic [NR-1:0]   Busy;
  logic            WriteEn0;
  logic [D-1:0]    Waddr0;
  logic [W-1:0]    DataIn0;
  logic            WriteEn1;
  logic [D-1:0]    Waddr1;
  logic [W-1:0]    DataIn1;
  logic            IssueEn;
  logic [D-1:0]    IssueAddr;
  logic            AnyBusy;

  modport master (
    output Raddr,
    output WriteEn0, Waddr0, DataIn0,
    output WriteEn1, Waddr1, DataIn1,
    output IssueEn, IssueAddr,
    input  DataOut, Busy, AnyBusy
  );

  modport slave (
    input  Raddr,
    input  WriteEn0, Waddr0, DataIn0,
    input  WriteEn1, Waddr1, DataIn1,
    input  IssueEn, IssueAddr,
    output DataOut, Busy, AnyBusy
  );
endinterface

// File: rtl/multi_port_reg_file.sv
// Multi-port register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module multi_port_reg_file #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int NR       = 2,
  parameter int ZERO_REG = 0
) (
  input logic Clk,
  input logic Reset,
  multi_port_reg_file_if.slave rf
);
  localparam int N = 2**D;

  logic [W-1:0]    regs [N];
  logic [N-1:0]    pend;
  logic [N-1:0]    pend_nxt;
  logic            we0;
  logic            we1;
  logic            ie;
  logic [D-1:0]    ra;
  logic [NR*W-1:0] dout;
  logic [NR-1:0]   busy;

  // Register 0 is write/issue-immune when hardwired to zero
  assign we0 = rf.WriteEn0 &&
    !(ZERO_REG != 0 && rf.Waddr0 == '0);
  assign we1 = rf.WriteEn1 &&
    !(ZERO_REG != 0 && rf.Waddr1 == '0);
  assign ie  = rf.IssueEn &&
    !(ZERO_REG != 0 && rf.IssueAddr == '0);

  always_comb begin
    pend_nxt = pend;
    for (int r = 0; r < N; r++) begin
      if (ie && rf.IssueAddr == D'(r))
        pend_nxt[r] = 1'b1;
      else if ((we0 && rf.Waddr0 == D'(r)) ||
               (we1 && rf.Waddr1 == D'(r)))
        pend_nxt[r] = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pend <= '0;
      for (int r = 0; r < N; r++)
        regs[r] <= '0;
    end else begin
      pend <= pend_nxt;
      if (we0)
        regs[rf.Waddr0] <= rf.DataIn0;
      // port 1 last so it wins a same-address collision
      if (we1)
        regs[rf.Waddr1] <= rf.DataIn1;
    end
  end

  always_comb begin
    dout = '0;
    busy = '0;
    ra   = '0;
    for (int k = 0; k < NR; k++) begin
      ra = rf.Raddr[k*D +: D];
      dout[k*W +: W] = regs[ra];
      busy[k] = pend[ra];
`ifdef REGFILE_BYPASS_EN
      if (Reset && we1 && rf.Waddr1 == ra) begin
        dout[k*W +: W] = rf.DataIn1;
        busy[k] = ie && rf.IssueAddr == ra;
      end else if (Reset && we0 && rf.Waddr0 == ra) begin
        dout[k*W +: W] = rf.DataIn0;
        busy[k] = ie && rf.IssueAddr == ra;
      end
`endif
      if (ZERO_REG != 0 && ra == '0) begin
        dout[k*W +: W] = '0;
        busy[k] = 1'b0;
      end
    end
  end

  assign rf.DataOut = dout;
  assign rf.Busy    = busy;
  assign rf.AnyBusy = |pend;
endmodule

// File: tb/tb_multi_port_reg_file.sv
// Scoreboard bench: one ordinary and one zero-reg instance
// share random stimulus, checked against an array model.
module tb_multi_port_reg_file;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int NR = 2;
  localparam int N  = 16;

  typedef struct {
    int              inst;
    string           tag;
    logic [NR*W-1:0] d;
    logic [NR-1:0]   b;
    logic            ab;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic [NR*D-1:0] raddr;
  logic            we0, we1, ie;
  logic [D-1:0]    wa0, wa1, ia;
  logic [W-1:0]    di0, di1;

  multi_port_reg_file_if #(.W(W), .D(D), .NR(NR)) bus0 ();
  multi_port_reg_file_if #(.W(W), .D(D), .NR(NR)) bus1 ();

  assign bus0.Raddr = raddr;
  assign bus0.WriteEn0 = we0;
  assign bus0.Waddr0 = wa0;
  assign bus0.DataIn0 = di0;
  assign bus0.WriteEn1 = we1;
  assign bus0.Waddr1 = wa1;
  assign bus0.DataIn1 = di1;
  assign bus0.IssueEn = ie;
  assign bus0.IssueAddr = ia;
  assign bus1.Raddr = raddr;
  assign bus1.WriteEn0 = we0;
  assign bus1.Waddr0 = wa0;
  assign bus1.DataIn0 = di0;
  assign bus1.WriteEn1 = we1;
  assign bus1.Waddr1 = wa1;
  assign bus1.DataIn1 = di1;
  assign bus1.IssueEn = ie;
  assign bus1.IssueAddr = ia;

  multi_port_reg_file #(
    .W(W), .D(D), .NR(NR), .ZERO_REG(0)
  ) u0 (
    .Clk(Clk), .Reset(Reset), .rf(bus0)
  );

  multi_port_reg_file #(
    .W(W), .D(D), .NR(NR), .ZERO_REG(1)
  ) u1 (
    .Clk(Clk), .Reset(Reset), .rf(bus1)
  );

  logic [W-1:0] mem [2][N];
  logic [N-1:0] mpend [2];
  exp_t q[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mpend[i] = '0;
      for (int r = 0; r < N; r++) mem[i][r] = '0;
    end
  endtask

  // Posedge effect of the current inputs on each instance
  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      logic [N-1:0] nxt;
      bit zr;
      zr = (i == 1);
      nxt = mpend[i];
      for (int r = 0; r < N; r++) begin
        bit hit0, hit1, iss;
        if (zr && r == 0) continue;
        hit0 = we0 && int'(wa0) == r;
        hit1 = we1 && int'(wa1) == r;
        iss = ie && int'(ia) == r;
        if (iss) nxt[r] = 1'b1;
        else if (hit0 || hit1) nxt[r] = 1'b0;
      end
      if (we0 && !(zr && wa0 == 0)) mem[i][wa0] = di0;
      if (we1 && !(zr && wa1 == 0)) mem[i][wa1] = di1;
      mpend[i] = nxt;
    end
  endtask

  function automatic exp_t expect_of(int i, string tag);
    exp_t x;
    x.inst = i;
    x.tag = tag;
    x.d = '0;
    x.b = '0;
    x.ab = 1'b0;
    if (!Reset) return x;
    x.ab = mpend[i] != 0;
    for (int k = 0; k < NR; k++) begin
      logic [D-1:0] a;
      logic [W-1:0] v;
      logic bz;
      a = raddr[k*D +: D];
      v = mem[i][a];
      bz = mpend[i][a];
`ifdef REGFILE_BYPASS_EN
      if (we1 && wa1 == a) begin
        v = di1;
        bz = ie && ia == a;
      end else if (we0 && wa0 == a) begin
        v = di0;
        bz = ie && ia == a;
      end
`endif
      if (i == 1 && a == 0) begin
        v = '0;
        bz = 1'b0;
      end
      x.d[k*W +: W] = v;
      x.b[k] = bz;
    end
    return x;
  endfunction

  task automatic cycle(string tag);
    q.push_back(expect_of(0, tag));
    q.push_back(expect_of(1, tag));
    @(posedge Clk);
    if (Reset) model_clock();
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; ie = 0;
    wa0 = '0; wa1 = '0; ia = '0;
    di0 = '0; di1 = '0;
  endtask

  task automatic rd(int a0, int a1);
    raddr = {D'(a1), D'(a0)};
  endtask

  always @(negedge Clk) begin
    while (q.size() != 0) begin
      logic [NR*W-1:0] ad;
      logic [NR-1:0] abz;
      logic aa;
      e = q.pop_front();
      if (e.inst == 0) begin
        ad = bus0.DataOut; abz = bus0.Busy; aa = bus0.AnyBusy;
      end else begin
        ad = bus1.DataOut; abz = bus1.Busy; aa = bus1.AnyBusy;
      end
      vectors++;
      if (ad !== e.d || abz !== e.b || aa !== e.ab) begin
        miscompares++;
        $display("FAIL %s inst%0d: got DataOut=%h Busy=%b AnyBusy=%b, want %h %b %b",
                 e.tag, e.inst, ad, abz, aa, e.d, e.b, e.ab);
      end
    end
  end

  initial begin
    idle();
    raddr = '0;
    Reset = 1'b0;
    model_reset();
    #1;
    for (int c = 0; c < 4; c++) begin
      raddr = NR*D'($urandom);
      we0 = 1'($urandom); wa0 = D'($urandom); di0 = W'($urandom);
      we1 = 1'($urandom); wa1 = D'($urandom); di1 = W'($urandom);
      ie = 1'($urandom); ia = D'($urandom);
      cycle("reset_hold");
    end
    idle();
    Reset = 1'b1;
    for (int r = 0; r < N; r += 2) begin
      rd(r, r + 1);
      cycle("reset_read");
    end

    we0 = 1; wa0 = 3; di0 = 8'hA5; rd(3, 0);
    cycle("wr_a5");
    idle(); rd(3, 3);
    cycle("rd_a5");

    we0 = 1; wa0 = 5; di0 = 8'h11;
    we1 = 1; wa1 = 5; di1 = 8'h22;
    cycle("dual_wr");
    idle(); rd(5, 3);
    cycle("rd_dual");

    ie = 1; ia = 7; rd(7, 5);
    cycle("issue7");
    idle();
    cycle("busy7");
    we1 = 1; wa1 = 7; di1 = 8'h3C;
    cycle("wb7");
    idle();
    cycle("rd7");

    ie = 1; ia = 2; we0 = 1; wa0 = 2; di0 = 8'h44; rd(2, 7);
    cycle("set_clr2");
    idle();
    cycle("rd2");

    we0 = 1; wa0 = 0; di0 = 8'hFF; ie = 1; ia = 0; rd(0, 2);
    cycle("zero_wr");
    idle();
    cycle("zero_rd");
    ie = 1; ia = 9; rd(9, 0);
    cycle("issue9");
    idle();
    cycle("busy9");
    Reset = 1'b0;
    model_reset();
    cycle("mid_reset");
    Reset = 1'b1;
    cycle("after_reset");

    for (int c = 0; c < 500; c++) begin
      raddr = NR*D'($urandom);
      we0 = ($urandom_range(0, 2) == 0);
      wa0 = D'($urandom); di0 = W'($urandom);
      we1 = ($urandom_range(0, 2) == 0);
      wa1 = D'($urandom); di1 = W'($urandom);
      ie = ($urandom_range(0, 2) == 0);
      ia = D'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        Reset = 1'b0;
        model_reset();
      end else begin
        Reset = 1'b1;
      end
      cycle("random");
    end

    idle();
    Reset = 1'b1;
    @(negedge Clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    if (vectors < 12) begin
      miscompares++;
      $display("FAIL monitor: %0d vectors checked, want >= 12", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
